// File: rtl/prog_loader.sv
// Serial program loader: receives an 8N1 framed image (SYNC, LEN, data, [checksum]) and writes it to RAM from 0.
// Optional feature macro: LOADER_CKSUM_EN (checksum byte required and checked when defined).
module prog_loader #(
    parameter int         CLK_HZ = 12000000,
    parameter int         BAUD   = 9600,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_run,
    output logic       busy,
    output logic       err,
    output logic [7:0] load_count
);
    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      rx_st, rx_st_n;
    logic           rx_s1, rx_s2, rx_q;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     rx_bit;
    logic [7:0]     rx_sh;
    logic           rx_valid, rx_ferr;
    logic           rx_fall, half_tick, full_tick;

    // Edge detect needs the line seen high first, so a held break cannot re-arm the receiver.
    assign rx_fall   = rx_q & ~rx_s2;
    assign half_tick = (rx_cnt == CW'(HALF - 1));
    assign full_tick = (rx_cnt == CW'(DIV - 1));

    always_comb begin
        rx_st_n = rx_st;
        case (rx_st)
            RX_IDLE:  if (rx_fall) rx_st_n = RX_START;
            RX_START: if (half_tick) rx_st_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && rx_bit == 3'd7) rx_st_n = RX_STOP;
            RX_STOP:  if (full_tick) rx_st_n = RX_IDLE;
            default:  rx_st_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_st    <= RX_IDLE;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_q     <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_st    <= rx_st_n;
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_q     <= rx_s2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (rx_st == RX_IDLE || (rx_st == RX_START && half_tick) || full_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_st == RX_IDLE)
                rx_bit <= '0;
            if (rx_st == RX_DATA && full_tick) begin
                rx_sh  <= {rx_s2, rx_sh[7:1]};
                rx_bit <= rx_bit + 1'b1;
            end
            if (rx_st == RX_STOP && full_tick) begin
                rx_valid <= rx_s2;
                rx_ferr  <= ~rx_s2;
            end
        end
    end

`ifdef LOADER_CKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CKSUM, S_DONE} state_t;
    logic [7:0] sum, sum_n;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;
`endif

    state_t     st, st_n;
    logic [7:0] len, len_n;
    logic [7:0] lc_n, lc_inc;
    logic       run_n, err_n, we_n;
    logic [7:0] addr_n, wdata_n;

    assign busy   = (st != S_IDLE) && (st != S_DONE);
    assign lc_inc = load_count + 8'd1;

    always_comb begin
        st_n    = st;
        len_n   = len;
        lc_n    = load_count;
        run_n   = cpu_run;
        err_n   = err;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
`ifdef LOADER_CKSUM_EN
        sum_n   = sum;
`endif
        if (rx_ferr) begin
            // A loaded image keeps running; only an in-progress frame is abandoned.
            err_n = 1'b1;
            if (st != S_DONE) st_n = S_IDLE;
        end else if (rx_valid) begin
            case (st)
                S_IDLE, S_DONE: begin
                    if (rx_sh == SYNC) begin
                        st_n  = S_LEN;
                        err_n = 1'b0;
                        lc_n  = 8'd0;
                        run_n = 1'b0;
                    end
                end
                S_LEN: begin
                    len_n = rx_sh;
`ifdef LOADER_CKSUM_EN
                    sum_n = 8'd0;
`endif
                    st_n  = S_DATA;
                end
                S_DATA: begin
                    we_n    = 1'b1;
                    addr_n  = load_count;
                    wdata_n = rx_sh;
                    lc_n    = lc_inc;
`ifdef LOADER_CKSUM_EN
                    sum_n   = sum + rx_sh;
                    if (lc_inc == len) st_n = S_CKSUM;
`else
                    if (lc_inc == len) begin
                        st_n  = S_DONE;
                        run_n = 1'b1;
                    end
`endif
                end
`ifdef LOADER_CKSUM_EN
                S_CKSUM: begin
                    if (rx_sh == sum) begin
                        st_n  = S_DONE;
                        run_n = 1'b1;
                    end else begin
                        st_n  = S_IDLE;
                        err_n = 1'b1;
                    end
                end
`endif
                default: st_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            len        <= 8'd0;
            load_count <= 8'd0;
            cpu_run    <= 1'b0;
            err        <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'd0;
            mem_wdata  <= 8'd0;
`ifdef LOADER_CKSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            st         <= st_n;
            len        <= len_n;
            load_count <= lc_n;
            cpu_run    <= run_n;
            err        <= err_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
`ifdef LOADER_CKSUM_EN
            sum        <= sum_n;
`endif
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; expected RAM writes are queued as bytes are sent and matched on mem_we.
module tb_prog_loader;
    localparam int CLK_HZ = 160000;
    localparam int BAUD   = 10000;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx = 1'b1;
    logic       mem_we, cpu_run, busy, err;
    logic [7:0] mem_addr, mem_wdata, load_count;

    always #5 clk = ~clk;

    prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .SYNC(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .err(err), .load_count(load_count)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  rxv_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write must match the oldest queued expectation; an unexpected write meets an X expectation.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_t e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            chk("ram_write", 32'({mem_addr, mem_wdata}), 32'(e));
        end
        if (dut.rx_valid) rxv_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic status(input string p, input logic [7:0] lc, input logic run,
                          input logic e, input logic bsy);
        chk({p, "_load_count"}, 32'(load_count), 32'(lc));
        chk({p, "_cpu_run"}, 32'(cpu_run), 32'(run));
        chk({p, "_err"}, 32'(err), 32'(e));
        chk({p, "_busy"}, 32'(busy), 32'(bsy));
        chk({p, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int r;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({mem_we, cpu_run, busy, err, mem_addr, mem_wdata, load_count}), 32'd0);
        rst_n = 1'b1;
        repeat (2000) @(negedge clk);
        chk("idle_no_rx", 32'(rxv_cnt), 32'd0);
        status("idle", 8'd0, 1'b0, 1'b0, 1'b0);

        // Normal load
        send_byte(8'hA5, 1'b1);
        chk("load_busy_after_sync", 32'(busy), 32'd1);
        send_byte(8'h03, 1'b1);
        push_wr(8'h00, 8'h11); push_wr(8'h01, 8'h22); push_wr(8'h02, 8'h33);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h66, 1'b1);
        status("load", 8'd3, 1'b1, 1'b0, 1'b0);

        // Bad checksum, then a good frame clears err
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        push_wr(8'h00, 8'h7F);
        send_byte(8'h7F, 1'b1);
        send_byte(8'h00, 1'b1);
        status("badck", 8'd1, !CK, CK, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        push_wr(8'h00, 8'h42);
        send_byte(8'h42, 1'b1);
        send_byte(8'h42, 1'b1);
        status("recover", 8'd1, 1'b1, 1'b0, 1'b0);

        // Framing error on third data byte of N=4
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        push_wr(8'h00, 8'h01); push_wr(8'h01, 8'h02);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b0);
        status("frame", 8'd2, 1'b0, 1'b1, 1'b0);

        // Break: line held low produces at most a framing error, never a byte
        r = rxv_cnt;
        uart_rx = 1'b0;
        repeat (40 * DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        chk("break_no_rx", 32'(rxv_cnt), 32'(r));
        status("break", 8'd2, 1'b0, 1'b1, 1'b0);

        // Full 256-byte image
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            push_wr(8'(i), 8'(i));
            send_byte(8'(i), 1'b1);
        end
        send_byte(8'h80, 1'b1);
        status("full", 8'd0, 1'b1, 1'b0, 1'b0);

        // Reload: cpu_run drops the cycle after the SYNC byte is received
        fork
            send_byte(8'hA5, 1'b1);
            begin
                int n = 0;
                while (!dut.rx_valid && n < 20 * DIV) begin
                    @(negedge clk);
                    n++;
                end
                chk("reload_rx_seen", 32'(dut.rx_valid), 32'd1);
                chk("reload_run_at_valid", 32'(cpu_run), 32'd1);
                @(negedge clk);
                chk("reload_run_next", 32'(cpu_run), 32'd0);
            end
        join
        send_byte(8'h05, 1'b1);
        push_wr(8'h00, 8'h09); push_wr(8'h01, 8'h0A);
        send_byte(8'h09, 1'b1);
        send_byte(8'h0A, 1'b1);
        chk("reload_busy", 32'(busy), 32'd1);
        chk("reload_count", 32'(load_count), 32'd2);

        // Reset mid-DATA: back to idle, no RAM activity, data bytes ignored
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        status("midrst", 8'd0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1);
        status("midrst_data", 8'd0, 1'b0, 1'b0, 1'b0);

        // Short glitch produces nothing
        r = rxv_cnt;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20 * DIV) @(negedge clk);
        chk("glitch_no_rx", 32'(rxv_cnt), 32'(r));
        status("glitch", 8'd0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1);
        chk("glitch_rearm_busy", 32'(busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
